// File: rtl/srambank_ctrl_128x4x72.sv
// rtl/srambank_ctrl_128x4x72.sv - request front-end for srambank_128x4x72_6t122
//
// Accepts valid/ready read and write requests and drives the bank pins from
// registers. Full-mask writes go straight to the bank. Partial-mask writes are
// done as read-modify-write. Zero-mask writes are accepted and dropped. Read
// data is captured into a small response FIFO. A credit count (FIFO occupancy
// plus reads in flight) holds reads back so that the FIFO cannot overflow.
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   req_valid/req_ready     request handshake
//   req_write, req_addr     request kind and word address
//   req_wdata, req_be       write data and byte enables (bit i -> bits 8i+7:8i)
//   rsp_valid/rsp_ready     response handshake
//   rsp_data                response data (FIFO head)
//   bank_address, bank_wd   registered bank address and write data
//   bank_read, bank_write   registered bank strobes
//   bank_banksel            bank_read | bank_write
//   bank_dataout            bank read data, valid the cycle after the read edge
module srambank_ctrl_128x4x72 #(
    parameter int AW        = 9,
    parameter int DW        = 72,
    parameter int BW        = 9,
    parameter int RSP_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [BW-1:0] req_be,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [AW-1:0] bank_address,
    output logic [DW-1:0] bank_wd,
    output logic          bank_banksel,
    output logic          bank_read,
    output logic          bank_write,
    input  logic [DW-1:0] bank_dataout
);

    localparam int PW  = $clog2(RSP_DEPTH);
    localparam int CW  = PW + 1;
    localparam int CRW = CW + 1;

    typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WAIT, RMW_WR} state_t;

    state_t        state, state_nxt;

    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [BW-1:0] lat_be;
    logic          lat_load;

    // rd_s1: a FIFO-bound read is on the bank pins; rd_s2: its data is on
    // bank_dataout and gets pushed at the next edge. RMW reads never set these.
    logic          rd_s1, rd_s2;

    logic [AW-1:0] nxt_addr;
    logic [DW-1:0] nxt_wd;
    logic          nxt_read, nxt_write, nxt_fifo_rd;
    logic          accept;
    logic [DW-1:0] merged;

    logic [DW-1:0] fifo_mem [RSP_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [CRW-1:0] credit;
    logic          push, pop;

    function automatic logic [DW-1:0] be_mask(input logic [BW-1:0] be);
        logic [DW-1:0] m;
        m = '0;
        for (int i = 0; i < BW; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    assign credit = CRW'(count) + CRW'(rd_s1) + CRW'(rd_s2);
    assign merged = (lat_wdata & be_mask(lat_be)) | (bank_dataout & ~be_mask(lat_be));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        accept      = 1'b0;
        lat_load    = 1'b0;
        nxt_read    = 1'b0;
        nxt_write   = 1'b0;
        nxt_fifo_rd = 1'b0;
        nxt_addr    = bank_address;
        nxt_wd      = bank_wd;
        case (state)
            IDLE: begin
                req_ready = !reset && (req_write || (credit < CRW'(RSP_DEPTH)));
                accept    = req_valid && req_ready;
                if (accept) begin
                    if (!req_write) begin
                        nxt_read    = 1'b1;
                        nxt_fifo_rd = 1'b1;
                        nxt_addr    = req_addr;
                    end else if (&req_be) begin
                        nxt_write = 1'b1;
                        nxt_wd    = req_wdata;
                        nxt_addr  = req_addr;
                    end else if (req_be != '0) begin
                        nxt_read  = 1'b1;
                        nxt_addr  = req_addr;
                        lat_load  = 1'b1;
                        state_nxt = RMW_RD;
                    end
                end
            end
            RMW_RD: begin
                state_nxt = RMW_WAIT;
            end
            RMW_WAIT: begin
                // Old word is on bank_dataout now; write back the merge.
                nxt_write = 1'b1;
                nxt_wd    = merged;
                nxt_addr  = lat_addr;
                state_nxt = RMW_WR;
            end
            RMW_WR: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_address <= '0;
            bank_wd      <= '0;
            bank_read    <= 1'b0;
            bank_write   <= 1'b0;
            bank_banksel <= 1'b0;
            rd_s1        <= 1'b0;
            rd_s2        <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_be       <= '0;
        end else begin
            bank_address <= nxt_addr;
            bank_wd      <= nxt_wd;
            bank_read    <= nxt_read;
            bank_write   <= nxt_write;
            bank_banksel <= nxt_read | nxt_write;
            rd_s1        <= nxt_fifo_rd;
            rd_s2        <= rd_s1;
            if (lat_load) begin
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
            end
        end
    end

    assign push      = rd_s2;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_valid = (count != '0);
    assign rsp_data  = fifo_mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bank_dataout;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Credit accounting guarantees room for every push.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(push && !pop && (count == CW'(RSP_DEPTH))));
        end
    end

endmodule

// File: doc/srambank_ctrl_128x4x72.md
Name: srambank_ctrl_128x4x72

Overview:
Request front-end that sits directly upstream of srambank_128x4x72_6t122 and drives its ADDRESS/wd/banksel/read/write pins. It accepts valid/ready read and write requests, including byte-masked writes, which it performs as read-modify-write. It captures bank read data into a response FIFO with valid/ready backpressure, so the bank's 1-cycle read latency is hidden from clients.

Parameters:
AW, 9, address width (512 words)
DW, 72, data width
BW, 9, byte-enable width (DW/8)
RSP_DEPTH, 4, response FIFO entries (power of 2, >=2)

Ports:
clk  input  1  clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request valid
req_ready  output  1  request accepted when req_valid&req_ready at rising edge
req_write  input  1  1=write, 0=read
req_addr  input  AW  word address
req_wdata  input  DW  write data
req_be  input  BW  byte enables; bit i covers wdata[8i+7:8i]
rsp_valid  output  1  read response valid
rsp_ready  input  1  response consumed when rsp_valid&rsp_ready
rsp_data  output  DW  read data
bank_address  output  AW  to bank ADDRESS
bank_wd  output  DW  to bank wd
bank_banksel  output  1  to bank banksel; equals bank_read|bank_write
bank_read  output  1  to bank read
bank_write  output  1  to bank write
bank_dataout  input  DW  from bank dataout; valid in the cycle after the edge that sampled bank_read

Behaviour:
- Reset: state IDLE; FIFO empty; pipeline flags cleared.
- Reset outputs: bank_address=0, bank_wd=0, bank_read=0, bank_write=0, bank_banksel=0, rsp_valid=0, rsp_data=0, req_ready=0.
- All bank_* outputs are registered. A request accepted at edge E0 presents its strobes during E0..E1, and the bank acts at E1.
- States: IDLE, RMW_RD, RMW_WAIT, RMW_WR.
- Credit counter: credit = fifo_count + inflight_reads, where inflight counts reads issued but not yet pushed (max 2).
- req_ready (IDLE only):
  - read: credit < RSP_DEPTH;
  - write: 1.
  - req_ready is a combinational function of state, credit and req_write.
- Read, accepted at E0:
  - bank_read=1 and bank_address=req_addr for one cycle.
  - At E2, bank_dataout is pushed into the FIFO and rsp_valid rises after E2.
  - Back-to-back reads sustain 1 per cycle while credit allows.
- Full write (req_be all ones), accepted at E0:
  - bank_write=1, bank_wd=req_wdata for one cycle.
  - Stays IDLE, so the next request can be accepted at E1.
- Zero mask (req_be==0): accepted, no bank access, no response.
- Partial write (mask neither zero nor all ones), accepted at E0:
  - Latch addr/wdata/be, issue bank_read, go to RMW_RD.
  - E1 -> RMW_WAIT.
  - At E2: merged = be-selected bytes of wdata, other bytes from bank_dataout; load bank_wd=merged, bank_write=1; go to RMW_WR.
  - E3 -> IDLE. req_ready=0 from E0 until IDLE.
  - The RMW read never enters the FIFO and never consumes credit.
  - Reads issued before the RMW drain normally; their dataout cycles precede the RMW's, so no reordering is needed.
- Ordering: bank accesses occur in acceptance order, so a read after a write to the same address returns the new data.
- FIFO:
  - rsp_data/rsp_valid come from the FIFO head (registered output, first-word-fall-through after push).
  - Simultaneous push and pop is legal at any occupancy.
  - Credit makes overflow impossible; a push when full is a design error to be asserted.
- Reset mid-operation (including mid-RMW): pending write is dropped, in-flight reads and FIFO contents are discarded, and bank strobes return to 0 immediately (asynchronous).
- Address wrap: none; req_addr is used as-is (0..511).

Test Plan:
- Reset then full write addr 5 data 72'h0123456789ABCDEF01 be=9'h1FF; read addr 5 accepted at E0 -> rsp_valid after E2 with rsp_data=72'h0123456789ABCDEF01; bank_read high for exactly one cycle.
- Write addr 9 = all ones; partial write addr 9 wdata=0 be=9'h001 -> bank_read, then 2 cycles later bank_write with bank_wd=72'hFF_FFFF_FFFF_FFFF_FF00; req_ready low 3 cycles; readback matches.
- rsp_ready=0; issue 6 reads to addrs 0..5 -> exactly 4 accepted, req_ready low; release rsp_ready -> responses come out in order 0..3, then reads 4,5 are accepted.
- Read addr 3, write addr 3 = 72'h55, read addr 3 back-to-back (1 per cycle) -> responses are old value, then 72'h55.
- req_be=0 write -> accepted, no bank strobe, no response.
- Assert reset in RMW_WAIT -> bank_write never asserts, FIFO empty, all outputs at reset values; a post-reset read shows the location unchanged.
